// File: rtl/mig_line_bridge.sv
// Bridges an L2 cache line port to the MIG DDR user interface, moving one line as BEATS beats.
// Optional per-byte write masking is enabled by defining WRITE_MASK_EN.
module mig_line_bridge #(
   parameter int LINE_W     = 128,
   parameter int DQ_W       = 64,
   parameter int ADDR_W     = 21,
   parameter int ADDR_LSB   = 2,
   parameter int BD_CYC     = 2,
   parameter int RD_TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [ADDR_W-1:0]          cache_addr,
   input  logic [LINE_W-1:0]          cache_wdata,
   input  logic [LINE_W/8-1:0]        cache_wstrb,
   input  logic                       cache_valid,
   output logic                       cache_ready,
   output logic [LINE_W-1:0]          cache_rdata,
   output logic                       rd_err,
   input  logic                       init_done,
   input  logic                       auto_refresh_req,
   input  logic                       ar_done,
   output logic [2:0]                 user_command_register,
   output logic [ADDR_W+ADDR_LSB-1:0] user_input_address,
   input  logic                       user_cmd_ack,
   output logic [DQ_W-1:0]            user_input_data,
   output logic [DQ_W/8-1:0]          user_data_mask,
   input  logic [DQ_W-1:0]            user_output_data,
   input  logic                       user_data_valid,
   output logic                       burst_done
);
   localparam int BEATS  = LINE_W / DQ_W;
   localparam int BYTES  = DQ_W / 8;
   localparam int LBYTES = LINE_W / 8;
   localparam int AW     = ADDR_W + ADDR_LSB;

   localparam logic [2:0] CMD_NOP  = 3'b000;
   localparam logic [2:0] CMD_INIT = 3'b010;
   localparam logic [2:0] CMD_WR   = 3'b100;
   localparam logic [2:0] CMD_RD   = 3'b110;

   typedef enum logic [3:0] {
      ST_STARTUP, ST_WAIT_INIT, ST_IDLE, ST_REFRESH,
      ST_WR_CMD, ST_WR_DATA, ST_WR_DONE,
      ST_RD_CMD, ST_RD_DATA, ST_RD_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          cmd_q, cmd_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [DQ_W-1:0]     wdat_q, wdat_d;
   logic [BYTES-1:0]    mask_q, mask_d;
   logic                bd_out_q, bd_out_d;
   logic                ready_q, ready_d;
   logic                err_out_q, err_out_d;
   logic [LINE_W-1:0]   rdata_q, rdata_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [LINE_W-1:0]   rbuf_q, rbuf_d;
   logic [3:0]          beat_q, beat_d;
   logic [7:0]          bd_q, bd_d;
   logic [7:0]          timer_q, timer_d;
   logic                err_q, err_d;
   logic [BYTES-1:0]    beat_mask;

`ifdef WRITE_MASK_EN
   // Strobes shift alongside the write line so the top slice always belongs to the next beat.
   logic [LBYTES-1:0] strb_q, strb_d;

   always_comb begin
      strb_d = strb_q;
      if (state_q == ST_IDLE && state_d == ST_WR_CMD)
         strb_d = cache_wstrb;
      else if ((state_q == ST_WR_CMD && user_cmd_ack) ||
               (state_q == ST_WR_DATA && beat_q != 4'(BEATS)))
         strb_d = strb_q << BYTES;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) strb_q <= '0;
      else        strb_q <= strb_d;
   end

   assign beat_mask = ~strb_q[LBYTES-1 -: BYTES];
`else
   assign beat_mask = '0;
`endif

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      wdat_d    = wdat_q;
      mask_d    = mask_q;
      bd_out_d  = bd_out_q;
      ready_d   = 1'b0;
      err_out_d = 1'b0;
      rdata_d   = rdata_q;
      line_d    = line_q;
      rbuf_d    = rbuf_q;
      beat_d    = beat_q;
      bd_d      = bd_q;
      timer_d   = timer_q;
      err_d     = err_q;
      case (state_q)
         ST_STARTUP: begin
            if (!init_done) begin
               cmd_d   = CMD_INIT;
               state_d = ST_WAIT_INIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_INIT: begin
            cmd_d = CMD_NOP;
            if (init_done) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            // ready_q marks the dead cycle in which a still-held valid must not be re-accepted.
            if (auto_refresh_req) begin
               state_d = ST_REFRESH;
            end else if (cache_valid && !user_cmd_ack && !ready_q) begin
               addr_d = AW'(cache_addr) << ADDR_LSB;
               beat_d = '0;
               if (|cache_wstrb) begin
                  cmd_d   = CMD_WR;
                  line_d  = cache_wdata;
                  state_d = ST_WR_CMD;
               end else begin
                  cmd_d   = CMD_RD;
                  state_d = ST_RD_CMD;
               end
            end
         end
         ST_REFRESH: begin
            if (ar_done) state_d = ST_IDLE;
         end
         ST_WR_CMD: begin
            if (user_cmd_ack) begin
               wdat_d  = line_q[LINE_W-1 -: DQ_W];
               mask_d  = beat_mask;
               line_d  = line_q << DQ_W;
               beat_d  = 4'd1;
               state_d = ST_WR_DATA;
            end
         end
         ST_WR_DATA: begin
            if (beat_q == 4'(BEATS)) begin
               wdat_d   = '0;
               mask_d   = '0;
               bd_out_d = 1'b1;
               bd_d     = 8'd1;
               state_d  = ST_WR_DONE;
            end else begin
               wdat_d = line_q[LINE_W-1 -: DQ_W];
               mask_d = beat_mask;
               line_d = line_q << DQ_W;
               beat_d = beat_q + 4'd1;
            end
         end
         ST_RD_CMD: begin
            if (user_cmd_ack) begin
               timer_d = '0;
               beat_d  = '0;
               err_d   = 1'b0;
               state_d = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            // The timer only guards the first beat; later gaps are left to the MIG.
            if (user_data_valid) begin
               rbuf_d = (rbuf_q << DQ_W) | LINE_W'(user_output_data);
               beat_d = beat_q + 4'd1;
               if (beat_q == 4'(BEATS - 1)) begin
                  bd_out_d = 1'b1;
                  bd_d     = 8'd1;
                  state_d  = ST_RD_DONE;
               end
            end else if (beat_q == '0) begin
               if (timer_q == 8'(RD_TIMEOUT - 1)) begin
                  err_d    = 1'b1;
                  bd_out_d = 1'b1;
                  bd_d     = 8'd1;
                  state_d  = ST_RD_DONE;
               end else begin
                  timer_d = timer_q + 8'd1;
               end
            end
         end
         ST_WR_DONE, ST_RD_DONE: begin
            if (bd_q == 8'(BD_CYC)) begin
               bd_out_d = 1'b0;
               cmd_d    = CMD_NOP;
               ready_d  = 1'b1;
               state_d  = ST_IDLE;
               if (state_q == ST_RD_DONE) begin
                  err_out_d = err_q;
                  rdata_d   = err_q ? '0 : rbuf_q;
               end
            end else begin
               bd_d = bd_q + 8'd1;
            end
         end
         default: state_d = ST_STARTUP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_STARTUP;
         cmd_q     <= CMD_NOP;
         addr_q    <= '0;
         wdat_q    <= '0;
         mask_q    <= '0;
         bd_out_q  <= 1'b0;
         ready_q   <= 1'b0;
         err_out_q <= 1'b0;
         rdata_q   <= '0;
         line_q    <= '0;
         rbuf_q    <= '0;
         beat_q    <= '0;
         bd_q      <= '0;
         timer_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         wdat_q    <= wdat_d;
         mask_q    <= mask_d;
         bd_out_q  <= bd_out_d;
         ready_q   <= ready_d;
         err_out_q <= err_out_d;
         rdata_q   <= rdata_d;
         line_q    <= line_d;
         rbuf_q    <= rbuf_d;
         beat_q    <= beat_d;
         bd_q      <= bd_d;
         timer_q   <= timer_d;
         err_q     <= err_d;
      end
   end

   assign cache_ready           = ready_q;
   assign cache_rdata           = rdata_q;
   assign rd_err                = err_out_q;
   assign user_command_register = cmd_q;
   assign user_input_address    = addr_q;
   assign user_input_data       = wdat_q;
   assign user_data_mask        = mask_q;
   assign burst_done            = bd_out_q;
endmodule

// File: tb/tb_mig_line_bridge.sv
// Randomised scoreboard bench for mig_line_bridge: a MIG responder model plus a cache-side monitor.
module tb_mig_line_bridge;
   localparam int LINE_W = 128, DQ_W = 64, ADDR_W = 21, ADDR_LSB = 2, BD_CYC = 2, RD_TIMEOUT = 255;
   localparam int BEATS = LINE_W / DQ_W, BYTES = DQ_W / 8, LBYTES = LINE_W / 8, AW = ADDR_W + ADDR_LSB;
   localparam logic [2:0] CMD_NOP = 3'b000, CMD_INIT = 3'b010, CMD_WR = 3'b100, CMD_RD = 3'b110;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [ADDR_W-1:0]   cache_addr;
   logic [LINE_W-1:0]   cache_wdata;
   logic [LBYTES-1:0]   cache_wstrb;
   logic                cache_valid;
   logic                cache_ready;
   logic [LINE_W-1:0]   cache_rdata;
   logic                rd_err;
   logic                init_done, auto_refresh_req, ar_done;
   logic [2:0]          user_command_register;
   logic [AW-1:0]       user_input_address;
   logic                user_cmd_ack;
   logic [DQ_W-1:0]     user_input_data;
   logic [BYTES-1:0]    user_data_mask;
   logic [DQ_W-1:0]     user_output_data;
   logic                user_data_valid;
   logic                burst_done;

   mig_line_bridge #(.LINE_W(LINE_W), .DQ_W(DQ_W), .ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB),
                     .BD_CYC(BD_CYC), .RD_TIMEOUT(RD_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_wstrb(cache_wstrb),
      .cache_valid(cache_valid), .cache_ready(cache_ready), .cache_rdata(cache_rdata), .rd_err(rd_err),
      .init_done(init_done), .auto_refresh_req(auto_refresh_req), .ar_done(ar_done),
      .user_command_register(user_command_register), .user_input_address(user_input_address),
      .user_cmd_ack(user_cmd_ack), .user_input_data(user_input_data), .user_data_mask(user_data_mask),
      .user_output_data(user_output_data), .user_data_valid(user_data_valid), .burst_done(burst_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit                wr;
      logic [AW-1:0]     addr;
      logic [LINE_W-1:0] line;
      logic [LBYTES-1:0] strb;
      int                ack_dly;
      int                gap;
      bit                tmo;
      bit                extra;
   } job_t;
   typedef struct {
      logic [LINE_W-1:0] rdata;
      bit                err;
   } rsp_t;

   job_t mig_q[$];
   rsp_t exp_q[$];
   int   due_q[$];
   int   n_checks = 0, n_pass = 0, n_txn = 0;
   bit   aborting = 1'b0;
   logic [LINE_W-1:0] last_rd = '0;

   task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic flag(input string name);
      n_checks++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   function automatic logic [DQ_W-1:0] beat_of(input logic [LINE_W-1:0] l, input int i);
      return l[(BEATS-1-i)*DQ_W +: DQ_W];
   endfunction

   function automatic logic [BYTES-1:0] mask_of(input logic [LBYTES-1:0] s, input int i);
      logic [BYTES-1:0] sel;
      sel = s[(BEATS-1-i)*BYTES +: BYTES];
`ifdef WRITE_MASK_EN
      return ~sel;
`else
      return sel & '0;
`endif
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W; i += 32) l[i +: 32] = $urandom;
      return l;
   endfunction

   // MIG responder: acks commands, checks write beats, returns read beats, records expected ready cycle.
   initial begin : mig_model
      job_t j;
      int   t0;
      user_cmd_ack = 1'b0; user_data_valid = 1'b0; user_output_data = '0;
      forever begin
         @(negedge clk);
         if (rst_n && !aborting && (user_command_register == CMD_WR || user_command_register == CMD_RD)) begin
            if (mig_q.size() == 0) begin
               flag("mig_unexpected_cmd");
            end else begin
               j = mig_q.pop_front();
               chk("mig_cmd", user_command_register, j.wr ? CMD_WR : CMD_RD);
               chk("mig_addr", user_input_address, j.addr);
               repeat (j.ack_dly) @(negedge clk);
               user_cmd_ack = 1'b1;
               t0 = cyc;
               @(negedge clk);
               user_cmd_ack = 1'b0;
               if (j.wr) begin
                  for (int i = 0; i < BEATS; i++) begin
                     if (i > 0) @(negedge clk);
                     if (!aborting) begin
                        chk($sformatf("wr_beat%0d", i), user_input_data, beat_of(j.line, i));
                        chk($sformatf("wr_mask%0d", i), user_data_mask, mask_of(j.strb, i));
                     end
                  end
                  due_q.push_back(t0 + BEATS + BD_CYC + 1);
               end else if (j.tmo) begin
                  due_q.push_back(t0 + RD_TIMEOUT + BD_CYC + 1);
               end else begin
                  repeat (j.gap) @(negedge clk);
                  for (int i = 0; i < BEATS; i++) begin
                     user_data_valid  = 1'b1;
                     user_output_data = beat_of(j.line, i);
                     if (i == BEATS - 1) due_q.push_back(cyc + BD_CYC + 1);
                     @(negedge clk);
                     user_data_valid = 1'b0;
                     if (i < BEATS - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
                  end
                  if (j.extra) begin
                     user_data_valid  = 1'b1;
                     user_output_data = {$urandom, $urandom};
                     @(negedge clk);
                     user_data_valid = 1'b0;
                  end
               end
            end
            for (int k = 0; k < 1000 && user_command_register != CMD_NOP; k++) @(negedge clk);
            if (user_command_register != CMD_NOP && !aborting) flag("mig_cmd_never_released");
         end
      end
   end

   // Cache-side monitor: pops the scoreboard on every ready pulse.
   initial begin : cache_mon
      int   bd_len = 0;
      bit   bd_prev = 1'b0, prev_ready = 1'b0;
      rsp_t r;
      forever begin
         @(negedge clk);
         if (prev_ready) chk("ready_pulse_width", cache_ready, 1'b0);
         if (cache_ready) begin
            if (exp_q.size() == 0) begin
               flag("unexpected_ready");
            end else begin
               r = exp_q.pop_front();
               chk("rdata", cache_rdata, r.rdata);
               chk("rd_err", rd_err, r.err);
               chk("burst_len", bd_prev ? bd_len : 0, BD_CYC);
               chk("burst_off_at_ready", burst_done, 1'b0);
               chk("cmd_nop_at_ready", user_command_register, CMD_NOP);
               if (due_q.size() == 0) flag("latency_no_reference");
               else chk("latency", cyc, due_q.pop_front());
            end
         end else if (rd_err) begin
            flag("rd_err_without_ready");
         end
         if (burst_done) bd_len = bd_prev ? bd_len + 1 : 1;
         bd_prev    = burst_done;
         prev_ready = cache_ready;
      end
   end

   task automatic prep(input bit wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line,
                       input logic [LBYTES-1:0] strb, input bit tmo, input int gap, input int ack_dly);
      job_t j;
      rsp_t r;
      j.wr = wr; j.addr = AW'(a) << ADDR_LSB; j.line = line; j.strb = strb;
      j.ack_dly = (ack_dly < 0) ? $urandom_range(0, 4) : ack_dly;
      j.gap = gap; j.tmo = tmo; j.extra = $urandom_range(0, 1);
      if (wr) begin
         r.rdata = last_rd; r.err = 1'b0;
      end else if (tmo) begin
         r.rdata = '0; r.err = 1'b1; last_rd = '0;
      end else begin
         r.rdata = line; r.err = 1'b0; last_rd = line;
      end
      mig_q.push_back(j);
      exp_q.push_back(r);
      cache_addr  = a;
      cache_wdata = wr ? line : rand_line();
      cache_wstrb = wr ? strb : '0;
   endtask

   task automatic wait_ready(input string label);
      int k;
      for (k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (cache_ready) break;
      end
      if (k == 2000) flag({"ready_timeout_", label});
      cache_valid = 1'b0;
      n_txn++;
      $display("txn %0d %s addr=%h rdata=%h rd_err=%0b cycle=%0d",
               n_txn, label, cache_addr, cache_rdata, rd_err, cyc);
   endtask

   task automatic issue(input string label, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [LINE_W-1:0] line, input logic [LBYTES-1:0] strb,
                        input bit tmo, input int gap, input int ack_dly);
      @(negedge clk);
      prep(wr, a, line, strb, tmo, gap, ack_dly);
      cache_valid = 1'b1;
      wait_ready(label);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n010;
      logic [LINE_W-1:0] l;
      logic [LBYTES-1:0] s;
      bit wr;
      rst_n = 1'b0; init_done = 1'b0; auto_refresh_req = 1'b0; ar_done = 1'b0;
      cache_addr = '0; cache_wdata = '0; cache_wstrb = '0; cache_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd", user_command_register, CMD_NOP);
      chk("rst_addr", user_input_address, '0);
      chk("rst_wdata", user_input_data, '0);
      chk("rst_mask", user_data_mask, '0);
      chk("rst_burst_done", burst_done, 1'b0);
      chk("rst_ready", cache_ready, 1'b0);
      chk("rst_rd_err", rd_err, 1'b0);
      chk("rst_rdata", cache_rdata, '0);

      // Startup with MIG not yet initialised: a single init command.
      rst_n = 1'b1;
      n010 = 0;
      repeat (10) begin
         @(negedge clk);
         if (user_command_register == CMD_INIT) n010++;
      end
      chk("init_cmd_cycles", n010, 1);
      chk("init_cmd_after", user_command_register, CMD_NOP);
      init_done = 1'b1;

      issue("write_directed", 1'b1, 21'h00010, 128'h0123456789ABCDEF_0011223344556677, '1, 1'b0, 0, 3);
      issue("read_directed", 1'b0, 21'h00010, {{16{4'hA}}, {16{4'h5}}}, '0, 1'b0, 0, -1);

      // Refresh and a request rise together: refresh wins, request follows ar_done.
      @(negedge clk);
      prep(1'b0, 21'h01234, rand_line(), '0, 1'b0, 1, -1);
      cache_valid = 1'b1;
      auto_refresh_req = 1'b1;
      @(negedge clk);
      auto_refresh_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("refresh_holds_cmd", user_command_register, CMD_NOP);
         @(negedge clk);
      end
      ar_done = 1'b1;
      @(negedge clk);
      ar_done = 1'b0;
      wait_ready("read_after_refresh");

      issue("read_timeout", 1'b0, 21'h00777, '0, '0, 1'b1, 0, -1);
      issue("read_last_legal_gap", 1'b0, 21'h00778, rand_line(), '0, 1'b0, RD_TIMEOUT - 1, -1);
      issue("write_strb_00f0", 1'b1, 21'h00020, rand_line(), 16'h00F0, 1'b0, 0, -1);

      for (int t = 0; t < 24; t++) begin
         wr = 1'($urandom_range(0, 1));
         l  = rand_line();
         s  = LBYTES'($urandom);
         if (s == '0) s = 1;
         issue(wr ? "write_rand" : "read_rand", wr, ADDR_W'($urandom), l, s, 1'b0,
               $urandom_range(0, 6), -1);
      end

      // Reset in the middle of a write burst: outputs must clear without a clock edge.
      @(negedge clk);
      prep(1'b1, 21'h1ABCD, rand_line(), '1, 1'b0, 0, 0);
      cache_valid = 1'b1;
      for (int k = 0; k < 50 && user_command_register != CMD_WR; k++) @(negedge clk);
      @(posedge clk);
      @(posedge clk);
      #2;
      aborting = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cmd", user_command_register, CMD_NOP);
      chk("async_rst_addr", user_input_address, '0);
      chk("async_rst_wdata", user_input_data, '0);
      chk("async_rst_mask", user_data_mask, '0);
      chk("async_rst_burst_done", burst_done, 1'b0);
      chk("async_rst_ready", cache_ready, 1'b0);
      chk("async_rst_rdata", cache_rdata, '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
